// File: rtl/vga_pkg.sv
// Shared VGA timing constants and framebuffer arbiter state encoding.
// Used by the sync generator, the framebuffer arbiter and its pixel shifter.
// No ports; import with vga_pkg::*.
package vga_pkg;

  localparam int H_ACTIVE = 640;             // visible pixels per line
  localparam int H_TOTAL  = 796;             // 640 + 60 + 56 + 40
  localparam int V_ACTIVE = 480;             // visible lines
  localparam int V_TOTAL  = 515;             // total lines per frame
  localparam int PPW      = 8;               // pixels per memory word, 1 bpp
  localparam int WPL      = H_ACTIVE / PPW;  // words per visible line
  localparam int OFF_W    = $clog2(PPW);     // pixel-within-word bits of pxl_x
  localparam int WIDX_W   = 10 - OFF_W;      // word-index bits of pxl_x

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRD  = 2'd1,
    DCAP = 2'd2,
    WR   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/vga_pix_shifter.sv
// Display pixel shifter: holds the prefetched word and serialises it MSB
// first onto pix_out, one bit per pixel tick.
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   pxl_tick        strobe marking the first clk of a new pixel
//   video           visible-area flag from the sync generator
//   word_start      current pixel is the first of a memory word
//   cap_en/cap_data load cap_data into the prefetch register
//   pix_out         current pixel bit, masked outside the visible area
//   pix_video       video delayed to line up with pix_out
module vga_pix_shifter
  import vga_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           pxl_tick,
  input  logic           video,
  input  logic           word_start,
  input  logic           cap_en,
  input  logic [PPW-1:0] cap_data,
  output logic           pix_out,
  output logic           pix_video
);

  logic [PPW-1:0] next_word_q, next_word_d;
  logic [PPW-1:0] shifter_q, shifter_d;
  logic           pix_video_q, pix_video_d;

  // The fetch for word k+1 always completes during word k, so a word
  // boundary can load next_word without checking whether it is fresh.
  always_comb begin
    next_word_d = next_word_q;
    shifter_d   = shifter_q;
    pix_video_d = pix_video_q;
    if (cap_en) begin
      next_word_d = cap_data;
    end
    if (pxl_tick && video) begin
      shifter_d = word_start ? next_word_q : (shifter_q << 1);
    end
    if (pxl_tick) begin
      pix_video_d = video;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      next_word_q <= '0;
      shifter_q   <= '0;
      pix_video_q <= 1'b0;
    end else begin
      next_word_q <= next_word_d;
      shifter_q   <= shifter_d;
      pix_video_q <= pix_video_d;
    end
  end

  assign pix_video = pix_video_q;
  assign pix_out   = shifter_q[PPW-1] & pix_video_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port 1-bpp framebuffer arbiter. Display scan-out prefetches one
// word ahead with absolute priority; a req/gnt writer gets every other slot,
// optionally only during vertical blanking.
// Ports:
//   clk, reset           system clock, synchronous active-low reset
//   pxl_x, pxl_y, video  sync generator coordinates and visible flag
//   pxl_tick             first clk of each new pixel
//   wr_req/addr/data     writer request, held until wr_gnt
//   wr_blank_only        restrict writes to lines >= V_ACTIVE
//   wr_gnt               one-cycle pulse coincident with the RAM write
//   mem_en/we/addr/wdata registered RAM controls
//   mem_rdata            RAM read data, valid 1 clk after a read cycle
//   pix_out, pix_video   serialised pixel and aligned visible flag
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pxl_x,
  input  logic [9:0]        pxl_y,
  input  logic              video,
  input  logic              pxl_tick,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PPW-1:0]    wr_data,
  input  logic              wr_blank_only,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PPW-1:0]    mem_wdata,
  input  logic [PPW-1:0]    mem_rdata,
  output logic              pix_out,
  output logic              pix_video
);

  arb_state_t        state_q, state_d;
  logic              disp_pend_q, disp_pend_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PPW-1:0]    mem_wdata_q, mem_wdata_d;
  logic              wr_gnt_q, wr_gnt_d;

  logic              word_start;
  logic [WIDX_W-1:0] word_idx;
  logic [9:0]        next_line;
  logic              mid_trig, line_trig;
  logic              wr_ok;

  assign word_start = (pxl_x[OFF_W-1:0] == '0);
  assign word_idx   = pxl_x[9:OFF_W];
  assign next_line  = (pxl_y == 10'(V_TOTAL - 1)) ? 10'd0 : pxl_y + 10'd1;

  // Mid-line fetches stop at the second-to-last word: the last word of a
  // line is fetched ahead of time, and word 0 of the next line comes from
  // the line prefetch at the end of the visible area.
  assign mid_trig  = pxl_tick && word_start && (pxl_x < 10'(H_ACTIVE)) &&
                     (pxl_y < 10'(V_ACTIVE)) && (word_idx < WIDX_W'(WPL - 1));
  assign line_trig = pxl_tick && (pxl_x == 10'(H_ACTIVE)) &&
                     (next_line < 10'(V_ACTIVE));

  assign wr_ok = wr_req && (!wr_blank_only || (pxl_y >= 10'(V_ACTIVE)));

  // A new trigger overrides the clear from DCAP so a fetch is never lost.
  always_comb begin
    disp_pend_d  = disp_pend_q;
    fetch_addr_d = fetch_addr_q;
    if (state_q == DCAP) begin
      disp_pend_d = 1'b0;
    end
    if (mid_trig) begin
      disp_pend_d  = 1'b1;
      fetch_addr_d = ADDR_W'(pxl_y) * ADDR_W'(WPL) + ADDR_W'(word_idx) + ADDR_W'(1);
    end else if (line_trig) begin
      disp_pend_d  = 1'b1;
      fetch_addr_d = ADDR_W'(next_line) * ADDR_W'(WPL);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (disp_pend_q) begin
          state_d = DRD;
        end else if (wr_ok) begin
          state_d = WR;
        end
      end
      DRD:  state_d = DCAP;
      DCAP: state_d = IDLE;
      WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM controls are registered, so they are computed from the IDLE
  // decision and appear in the same cycle as DRD or WR.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    wr_gnt_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == IDLE) begin
      if (disp_pend_q) begin
        mem_en_d   = 1'b1;
        mem_addr_d = fetch_addr_q;
      end else if (wr_ok) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        wr_gnt_d    = 1'b1;
        mem_addr_d  = wr_addr;
        mem_wdata_d = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      disp_pend_q  <= 1'b0;
      fetch_addr_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_gnt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_pend_q  <= disp_pend_d;
      fetch_addr_q <= fetch_addr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_gnt_q     <= wr_gnt_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_gnt    = wr_gnt_q;

  vga_pix_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .pxl_tick   (pxl_tick),
    .video      (video),
    .word_start (word_start),
    .cap_en     (state_q == DCAP),
    .cap_data   (mem_rdata),
    .pix_out    (pix_out),
    .pix_video  (pix_video)
  );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter. Expected RAM reads and writes are
// queued when stimulus is driven and popped as the DUT issues RAM cycles.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pxl_x, pxl_y;
  logic        video, pxl_tick;
  logic        wr_req, wr_blank_only;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_gnt, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        pix_out, pix_video;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fetch;
    logic [15:0] addr;
  } vec_t;

  logic [15:0] rd_q[$];
  wr_exp_t     wr_q[$];
  int          gnt_cyc_q[$];

  int tests_run = 0;
  int failed = 0;
  int cyc = 0;
  int n_gnt = 0;
  int wr_more = 0;
  int last_gnt_cyc = -1;
  int last_rd_cyc = -1;
  int stim_cyc = 0;

  vga_fb_arbiter #(.ADDR_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pxl_x         (pxl_x),
    .pxl_y         (pxl_y),
    .video         (video),
    .pxl_tick      (pxl_tick),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_blank_only (wr_blank_only),
    .wr_gnt        (wr_gnt),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .pix_out       (pix_out),
    .pix_video     (pix_video)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents are a fixed function of the address.
  function automatic logic [7:0] ram_word(input logic [15:0] a);
    return a[7:0] ^ 8'h35;
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= ram_word(mem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic vid, input logic exp_fetch,
                               input logic [15:0] exp_addr);
    pxl_x    = x;
    pxl_y    = y;
    video    = vid;
    pxl_tick = 1'b1;
    stim_cyc = cyc;
    if (exp_fetch) rd_q.push_back(exp_addr);
  endtask

  // Observe n cycles at the falling edge; the writer drops or renews its
  // request when it sees a grant, and the pixel tick lasts one clk.
  task automatic watch(input int n);
    wr_exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wr_gnt) checkOutput("gnt_mem_en_we", 32'({mem_en, mem_we}), 32'd3);
      if (mem_en && mem_we) begin
        n_gnt++;
        last_gnt_cyc = cyc;
        gnt_cyc_q.push_back(cyc);
        tests_run++;
        if (wr_q.size() == 0) begin
          failed++;
          $display("[TB] FAIL unexpected_write: got addr %0h, expected no write", mem_addr);
        end else begin
          tests_run--;
          e = wr_q.pop_front();
          checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("wr_data", 32'(mem_wdata), 32'(e.data));
          checkOutput("wr_gnt", 32'(wr_gnt), 32'd1);
        end
        if (wr_more > 0) begin
          wr_more--;
          wr_addr = wr_addr + 16'h0101;
          wr_data = wr_data + 8'h11;
          wr_q.push_back('{wr_addr, wr_data});
        end else begin
          wr_req = 1'b0;
        end
      end else if (mem_en) begin
        last_rd_cyc = cyc;
        checkOutput("no_gnt_on_read", 32'(wr_gnt), 32'd0);
        tests_run++;
        if (rd_q.size() == 0) begin
          failed++;
          $display("[TB] FAIL unexpected_read: got addr %0h, expected no read", mem_addr);
        end else begin
          tests_run--;
          checkOutput("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
        end
      end
      pxl_tick = 1'b0;
    end
  endtask

  task automatic drained(input string name);
    checkOutput({name, "_rd_pending"}, 32'(rd_q.size()), 32'd0);
    checkOutput({name, "_wr_pending"}, 32'(wr_q.size()), 32'd0);
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin
    vec_t        vecs[13];
    logic [7:0]  exp_word;
    int          g0, start;

    vecs[0]  = '{10'd640, 10'd4,   1'b1, 16'd400};
    vecs[1]  = '{10'd8,   10'd0,   1'b1, 16'd2};
    vecs[2]  = '{10'd632, 10'd0,   1'b0, 16'd0};
    vecs[3]  = '{10'd0,   10'd0,   1'b1, 16'd1};
    vecs[4]  = '{10'd624, 10'd10,  1'b1, 16'd879};
    vecs[5]  = '{10'd640, 10'd479, 1'b0, 16'd0};
    vecs[6]  = '{10'd640, 10'd514, 1'b1, 16'd0};
    vecs[7]  = '{10'd640, 10'd478, 1'b1, 16'd38320};
    vecs[8]  = '{10'd4,   10'd0,   1'b0, 16'd0};
    vecs[9]  = '{10'd8,   10'd480, 1'b0, 16'd0};
    vecs[10] = '{10'd16,  10'd479, 1'b1, 16'd38323};
    vecs[11] = '{10'd700, 10'd5,   1'b0, 16'd0};
    vecs[12] = '{10'd640, 10'd500, 1'b0, 16'd0};

    reset = 1'b0; pxl_x = '0; pxl_y = '0; video = 1'b0; pxl_tick = 1'b0;
    wr_req = 1'b0; wr_blank_only = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_wr_gnt", 32'(wr_gnt), 32'd0);
    checkOutput("rst_pix_video", 32'(pix_video), 32'd0);
    reset = 1'b1;

    // Plain write so the address/data registers hold non-zero values.
    wr_addr = 16'h1234; wr_data = 8'h5A; wr_req = 1'b1;
    wr_q.push_back('{wr_addr, wr_data});
    watch(4);
    drained("first_write");

    // Reset with a fetch pending and a fresh write request: both abandoned.
    applyStimulus(10'd640, 10'd4, 1'b0, 1'b0, 16'd0);
    watch(1);
    g0 = n_gnt;
    reset = 1'b0; wr_req = 1'b1; wr_addr = 16'h2222; wr_data = 8'h77;
    watch(3);
    checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("midrst_mem_en", 32'(mem_en), 32'd0);
    reset = 1'b1; wr_req = 1'b0;
    watch(5);
    checkOutput("midrst_no_gnt", 32'(n_gnt - g0), 32'd0);
    drained("midrst");

    for (int i = 0; i < 13; i++) begin
      last_rd_cyc = -1;
      applyStimulus(vecs[i].x, vecs[i].y,
                    (vecs[i].x < 10'd640) && (vecs[i].y < 10'd480),
                    vecs[i].fetch, vecs[i].addr);
      start = stim_cyc;
      watch(6);
      if (vecs[i].fetch)
        checkOutput($sformatf("vec%0d_latency", i), 32'(last_rd_cyc), 32'(start + 2));
      drained($sformatf("vec%0d", i));
    end

    // Line prefetch of line 5 then scan out its first word.
    applyStimulus(10'd640, 10'd4, 1'b0, 1'b1, 16'd400);
    watch(6);
    drained("pix_prefetch");
    exp_word = ram_word(16'd400);
    for (int x = 0; x < 8; x++) begin
      pxl_x = 10'(x); pxl_y = 10'd5; video = 1'b1; pxl_tick = 1'b1;
      if (x == 0) rd_q.push_back(16'd401);
      watch(1);
      checkOutput($sformatf("pix_x%0d", x), 32'(pix_out), 32'(exp_word[7 - x]));
      checkOutput($sformatf("pix_video_x%0d", x), 32'(pix_video), 32'd1);
      watch(1);
    end
    applyStimulus(10'd640, 10'd5, 1'b0, 1'b1, 16'd480);
    watch(1);
    checkOutput("pix_blank_out", 32'(pix_out), 32'd0);
    checkOutput("pix_blank_video", 32'(pix_video), 32'd0);
    watch(6);
    drained("pix_line");

    // Write request seen in the same decision cycle the trigger arrives.
    wr_req = 1'b1; wr_addr = 16'h0ABC; wr_data = 8'h3C;
    wr_q.push_back('{wr_addr, wr_data});
    applyStimulus(10'd640, 10'd4, 1'b0, 1'b1, 16'd400);
    start = stim_cyc;
    watch(8);
    checkOutput("coll1_gnt_cyc", 32'(last_gnt_cyc), 32'(start + 1));
    checkOutput("coll1_rd_cyc", 32'(last_rd_cyc), 32'(start + 3));
    drained("coll1");

    // Display already pending when the writer asks: read first, then write.
    applyStimulus(10'd640, 10'd9, 1'b0, 1'b1, 16'd800);
    start = stim_cyc;
    watch(1);
    wr_req = 1'b1; wr_addr = 16'h0DEF; wr_data = 8'hC3;
    wr_q.push_back('{wr_addr, wr_data});
    watch(8);
    checkOutput("coll2_rd_cyc", 32'(last_rd_cyc), 32'(start + 2));
    checkOutput("coll2_gnt_cyc", 32'(last_gnt_cyc), 32'(start + 5));
    drained("coll2");

    // Blank-only writer waits for vertical blanking.
    wr_blank_only = 1'b1; pxl_x = 10'd200; pxl_y = 10'd100;
    g0 = n_gnt;
    wr_req = 1'b1; wr_addr = 16'h4000; wr_data = 8'h81;
    wr_q.push_back('{wr_addr, wr_data});
    watch(10);
    checkOutput("blank_no_gnt", 32'(n_gnt - g0), 32'd0);
    pxl_y = 10'd480;
    start = cyc;
    watch(4);
    checkOutput("blank_gnt_count", 32'(n_gnt - g0), 32'd1);
    checkOutput("blank_gnt_cyc", 32'(last_gnt_cyc), 32'(start + 1));
    drained("blank");
    wr_blank_only = 1'b0;

    // Continuous writer: a grant every second clock.
    pxl_y = 10'd100;
    g0 = n_gnt;
    gnt_cyc_q.delete();
    wr_more = 4;
    wr_req = 1'b1; wr_addr = 16'h0100; wr_data = 8'h11;
    wr_q.push_back('{wr_addr, wr_data});
    watch(12);
    checkOutput("b2b_count", 32'(n_gnt - g0), 32'd5);
    for (int i = 1; i < 5; i++) begin
      if (gnt_cyc_q.size() > i)
        checkOutput($sformatf("b2b_gap%0d", i), 32'(gnt_cyc_q[i] - gnt_cyc_q[i - 1]), 32'd2);
    end
    drained("b2b");

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
